// File: rtl/mem_bus_pkg.sv
// Shared CPU memory-bus definitions: widths, reset vector, word/byte-enable types,
// the stall FSM encoding and the byte-lane merge helper.
package mem_bus_pkg;
  localparam int BUS_W = 32;
  localparam int BE_W = 4;
  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

  typedef logic [BE_W-1:0] be_t;
  typedef logic [BUS_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STALL  = 2'd1,
    ST_ACCEPT = 2'd2
  } stall_state_t;

  // Lane i of new_w replaces lane i of old_w wherever be[i] is set (little-endian lanes).
  function automatic word_t lane_merge(input word_t old_w, input word_t new_w, input be_t be);
    word_t m;
    m = old_w;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) m[8*i +: 8] = new_w[8*i +: 8];
    end
    return m;
  endfunction
endpackage

// File: rtl/mips_mem_responder_if.sv
// CPU memory bus between the pipeline (master) and the RAM responder (slave).
// Handshake: a request (read or write) is held by the master; it is accepted on the
// rising edge where the request is high and waitrequest is low. readdata is valid the
// cycle after the accepting edge of a read and is held until the next accepted read.
interface mips_mem_responder_if;
  import mem_bus_pkg::*;

  logic [31:0] address;
  logic        read;
  logic        write;
  be_t         byteenable;
  word_t       writedata;
  logic        waitrequest;
  word_t       readdata;
  logic        access_error;

  modport master (
    output address, read, write, byteenable, writedata,
    input  waitrequest, readdata, access_error
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output waitrequest, readdata, access_error
  );
endinterface

// File: rtl/mem_resp_ram.sv
// Single-port word RAM with per-byte write enables and a synchronous read register.
// Contents are never cleared by reset.
module mem_resp_ram
  import mem_bus_pkg::*;
#(
  parameter int    MEM_WORDS = 1024,
  parameter string INIT_FILE = "",
  localparam int   AW = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          i_we,
  input  be_t           i_be,
  input  logic          i_re,
  input  logic [AW-1:0] i_idx,
  input  word_t         i_wdata,
  output word_t         o_rdata
);

  word_t r_mem [MEM_WORDS];
  word_t r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_idx] <= lane_merge(r_mem[i_idx], i_wdata, i_be);
    if (i_re) r_rdata <= r_mem[i_idx];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mips_mem_responder.sv
// Memory-bus responder: address decode, stall FSM (fixed or LFSR-driven wait states),
// sticky access-error flag and registered read data over a byte-lane RAM.
module mips_mem_responder
  import mem_bus_pkg::*;
#(
  parameter int          MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = RESET_VECTOR,
  parameter int          WAIT_CYCLES = 0,
  parameter bit          RAND_STALL  = 1'b0,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5,
  parameter string       INIT_FILE   = ""
) (
  input  logic                 clk,
  input  logic                 reset,
  mips_mem_responder_if.slave  bus,
  output stall_state_t         o_dbg_state
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [7:0] FIXED_TGT = 8'(WAIT_CYCLES);

  // Fibonacci step for x^8+x^6+x^5+x^4+1.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  logic [7:0]   r_cnt;
  logic [7:0]   r_stall_tgt;
  logic [7:0]   r_lfsr;
  logic         r_err;
  logic         r_rd_zero;
  stall_state_t r_state;

  logic         w_req;
  logic [7:0]   w_live_tgt;
  logic [7:0]   w_tgt;
  logic         w_wait;
  logic         w_accept;
  logic [31:0]  w_offset;
  logic         w_in_range;
  logic         w_illegal;
  word_t        w_ram_q;

  assign w_req      = bus.read | bus.write;
  assign w_live_tgt = RAND_STALL ? {6'd0, r_lfsr[1:0]} : FIXED_TGT;
  // The first cycle of a request uses the live target; later cycles use the latched copy.
  assign w_tgt      = (r_cnt == 8'd0) ? w_live_tgt : r_stall_tgt;
  assign w_wait     = w_req && (r_cnt != w_tgt);
  assign w_accept   = w_req && !w_wait;

  // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
  assign w_offset   = bus.address - BASE_ADDR;
  assign w_in_range = (w_offset[31:AW+2] == '0);
  assign w_illegal  = !w_in_range || (w_offset[1:0] != 2'b00) || (bus.read && bus.write);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= 8'd0;
      r_stall_tgt <= 8'd0;
      r_lfsr      <= LFSR_SEED;
      r_err       <= 1'b0;
      r_rd_zero   <= 1'b1;
      r_state     <= ST_IDLE;
    end else begin
      if (!w_req || w_accept) begin
        r_cnt   <= 8'd0;
        r_state <= ST_IDLE;
      end else begin
        r_cnt   <= r_cnt + 8'd1;
        r_state <= (r_cnt + 8'd1 == w_tgt) ? ST_ACCEPT : ST_STALL;
      end
      if (w_req && (r_cnt == 8'd0)) r_stall_tgt <= w_live_tgt;
      if (w_accept) begin
        r_lfsr <= lfsr_step(r_lfsr);
        if (w_illegal) r_err <= 1'b1;
        // An illegal read returns zero; the RAM read register is simply left alone.
        if (bus.read) r_rd_zero <= w_illegal;
      end
    end
  end

  mem_resp_ram #(
    .MEM_WORDS (MEM_WORDS),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_accept && bus.write && !w_illegal),
    .i_be    (bus.byteenable),
    .i_re    (w_accept && bus.read && !w_illegal),
    .i_idx   (w_offset[AW+1:2]),
    .i_wdata (bus.writedata),
    .o_rdata (w_ram_q)
  );

  assign bus.waitrequest  = w_wait;
  assign bus.readdata     = r_rd_zero ? '0 : w_ram_q;
  assign bus.access_error = r_err;
  assign o_dbg_state      = r_state;

endmodule
